// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter slice.
// Holds the arbiter state encoding, the register-bus data width and the
// default bus-hang timeout used when the top is instantiated without overrides.
package wb_pkg;

    // Data width of the shared register bus.
    localparam int WB_DAT_W    = 8;

    // Default number of stb cycles without ack before an error is returned.
    localparam int TIMEOUT_DEF = 255;

    // Arbiter ownership states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/wb_master_arb_if.sv
// Wishbone point-to-point bundle: request signals from a master, response
// signals back to it. The master modport is used by a bus initiator and the
// slave modport by the responder; clock and reset stay outside the bundle.
interface wb_master_arb_if #(
    parameter int ADDR_W = 16
);
    logic                        cyc;
    logic                        stb;
    logic                        we;
    logic [ADDR_W-1:0]           adr;
    logic [wb_pkg::WB_DAT_W-1:0] dat_w;   // write data, master -> slave
    logic [wb_pkg::WB_DAT_W-1:0] dat_r;   // read data, slave -> master
    logic                        ack;
    logic                        err;

    modport master (output cyc, stb, we, adr, dat_w, input  dat_r, ack, err);
    modport slave  (input  cyc, stb, we, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_timeout_mon.sv
// Bus-hang monitor: counts owner stb cycles without ack and flags a timeout.
// Ports: CLK/RST; i_idle (no owner), i_stb (raw owner stb), i_ack (OR-ed slave ack);
//        o_to_hit (combinational timeout pulse), o_timeout_cnt (saturating event count).
module wb_timeout_mon #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_idle,
    input  logic       i_stb,
    input  logic       i_ack,
    output logic       o_to_hit,
    output logic [7:0] o_timeout_cnt
);
    localparam logic [TO_W-1:0] LP_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt;
    logic [7:0]      r_evt_cnt;

    // An ack on the terminal cycle wins over the timeout.
    assign o_to_hit      = ~i_idle & i_stb & ~i_ack & (r_cnt == LP_LAST);
    assign o_timeout_cnt = r_evt_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_evt_cnt <= '0;
        end else begin
            if (i_idle || !i_stb || i_ack || o_to_hit)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (o_to_hit && (r_evt_cnt != 8'hFF))
                r_evt_cnt <= r_evt_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/wb_master_arb.sv
// Two-master, single-slave Wishbone arbiter with round-robin, cycle locking and hang timeout.
// Ports: CLK/RST; m0/m1 (master-facing buses), s (slave-facing bus);
//        o_grant (one-hot owner), o_timeout_cnt (saturating timeout count).
module wb_master_arb
    import wb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    wb_master_arb_if.slave   m0,
    wb_master_arb_if.slave   m1,
    wb_master_arb_if.master  s,
    output logic [1:0]       o_grant,
    output logic [7:0]       o_timeout_cnt
);
    state_t      r_state, w_state_nxt;
    logic        r_last_m1, w_last_m1_nxt;   // 1: m1 was served most recently
    logic [1:0]  r_grant, w_grant_nxt;

    logic                w_own_stb;
    logic                w_to_hit;
    logic [ADDR_W-1:0]   w_s_adr;
    logic                w_unused_s_err;

    // The slave bus error line is not part of this arbiter's response path.
    assign w_unused_s_err = s.err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_last_m1 <= 1'b1;
            r_grant   <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_last_m1 <= w_last_m1_nxt;
            r_grant   <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_last_m1_nxt = r_last_m1;
        case (r_state)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc)
                    w_state_nxt = r_last_m1 ? ST_OWN0 : ST_OWN1;
                else if (m0.cyc)
                    w_state_nxt = ST_OWN0;
                else if (m1.cyc)
                    w_state_nxt = ST_OWN1;
                if (w_state_nxt == ST_OWN0) w_last_m1_nxt = 1'b0;
                if (w_state_nxt == ST_OWN1) w_last_m1_nxt = 1'b1;
            end
            // Ownership is locked until the owner drops cyc; the return
            // through IDLE gives one dead cycle between owners.
            ST_OWN0: if (!m0.cyc) w_state_nxt = ST_IDLE;
            ST_OWN1: if (!m1.cyc) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        w_grant_nxt = {w_state_nxt == ST_OWN1, w_state_nxt == ST_OWN0};
    end

    assign o_grant = r_grant;

    // Request path: combinational mux of the owner's signals, zero in IDLE.
    always_comb begin
        s.cyc     = 1'b0;
        w_own_stb = 1'b0;
        s.we      = 1'b0;
        w_s_adr   = '0;
        s.dat_w   = '0;
        if (r_grant[0]) begin
            s.cyc     = m0.cyc;
            w_own_stb = m0.stb;
            s.we      = m0.we;
            w_s_adr   = m0.adr;
            s.dat_w   = m0.dat_w;
        end else if (r_grant[1]) begin
            s.cyc     = m1.cyc;
            w_own_stb = m1.stb;
            s.we      = m1.we;
            w_s_adr   = m1.adr;
            s.dat_w   = m1.dat_w;
        end
    end

    // The strobe is withheld on the timeout cycle so the slave never sees
    // a request whose response has already been replaced by err.
    assign s.stb = w_own_stb & ~w_to_hit;
    assign s.adr = w_s_adr;

    // Response path: only the current owner sees ack/err/data.
    assign m0.ack   = s.ack & r_grant[0];
    assign m1.ack   = s.ack & r_grant[1];
    assign m0.err   = w_to_hit & r_grant[0];
    assign m1.err   = w_to_hit & r_grant[1];
    assign m0.dat_r = r_grant[0] ? s.dat_r : '0;
    assign m1.dat_r = r_grant[1] ? s.dat_r : '0;

    wb_timeout_mon #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_to_mon (
        .CLK           (CLK),
        .RST           (RST),
        .i_idle        (r_grant == 2'b00),
        .i_stb         (w_own_stb),
        .i_ack         (s.ack),
        .o_to_hit      (w_to_hit),
        .o_timeout_cnt (o_timeout_cnt)
    );
endmodule

// File: doc/wb_master_arb.md
Name: wb_master_arb

Overview:
- Two-master, single-slave Wishbone arbiter for the shared 8-bit register bus.
- Lets the RBCP-to-Wishbone bridge (master 0) and an autonomous on-chip sequencer (master 1, e.g. a periodic I2C/SPI/UART poller) share the register table and the I2C/SPI/UART cores.
- Sits between the masters and the existing slave-select/ack-OR logic.
- Provides round-robin fairness, cycle locking, and a bus-hang timeout that returns a Wishbone error to the owning master.

Parameters:
- ADDR_W, 16, width of Wishbone address.
- TIMEOUT, 255, cycles of stb without ack before err is generated; legal range 2..65535.
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle/strobe/write
- m0_adr  in  ADDR_W  master 0 address
- m0_dat_i  in  8  master 0 write data
- m0_dat_o  out  8  read data to master 0
- m0_ack, m0_err  out  1 each  ack/error to master 0
- m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_i, m1_dat_o, m1_ack, m1_err  same as m0, for master 1
- s_cyc, s_stb, s_we  out  1 each  to slaves
- s_adr  out  ADDR_W  to slaves
- s_dat_o  out  8  write data to slaves
- s_dat_i  in  8  OR-ed slave read data
- s_ack  in  1  OR-ed slave ack
- o_grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1)
- o_timeout_cnt  out  8  saturating count of timeouts since reset

Behaviour:
- Reset: state IDLE, last-served = m1 (so m0 wins the first tie), o_grant = 0, timeout counter = 0, o_timeout_cnt = 0.
- Reset outputs: all s_* outputs 0; m*_ack, m*_err and m*_dat_o all 0.
- FSM states: IDLE, OWN0, OWN1. State and grant are registered.
- IDLE transitions:
  - only m0_cyc → OWN0; only m1_cyc → OWN1.
  - both → the master not in last-served; last-served is updated on entry.
- OWNx: hold while mx_cyc = 1. When mx_cyc = 0 → IDLE, giving one dead cycle between owners.
- Cycle locking: the other master's requests are ignored for the whole OWNx period.
- Latency: grant is asserted the cycle after cyc is first seen; the first s_stb follows grant with zero added latency.
- Request/slave-path muxing is combinational from the owner's signals:
  - in OWNx: s_cyc = mx_cyc, s_stb = mx_stb & ~to_hit, s_we = mx_we, s_adr = mx_adr, s_dat_o = mx_dat_i.
  - in IDLE: all s_* outputs are 0.
- Response path:
  - mx_ack = s_ack & grant[x].
  - mx_dat_o = grant[x] ? s_dat_i : 0.
  - the non-owner always sees ack = 0, err = 0, dat = 0.
- Timeout counter:
  - clears when the owner's stb = 0, when s_ack = 1, or in IDLE.
  - otherwise increments by 1 per cycle.
  - to_hit = (counter == TIMEOUT−1) & owner stb & ~s_ack.
  - on to_hit: mx_err = 1 for exactly one cycle, s_stb is forced 0 that cycle, the counter clears, and o_timeout_cnt increments (saturating at 255).
  - ownership is retained after to_hit; the master decides whether to drop cyc.
- Simultaneous events:
  - s_ack on the same cycle as to_hit → ack wins, no err, no count.
  - owner drops cyc while stb is pending → IDLE next cycle; a late s_ack arriving in IDLE is discarded.
- Reset mid-transfer: immediate return to the reset state; no ack or err is issued.
- Widths: counter comparisons are unsigned at TO_W bits; o_timeout_cnt saturates and never wraps.

Decomposition:
- Shared package wb_pkg:
  - state encoding constants ST_IDLE, ST_OWN0, ST_OWN1.
  - WB_DAT_W = 8.
  - default TIMEOUT constant.
- One natural sub-module: wb_timeout_mon, holding the counter, the to_hit compare and the saturating event counter. It is instantiated once, driven by the muxed owner stb and s_ack.

Test Plan:
- Single master: m0 write to adr 0x0010, data 0xA5; slave acks 3 cycles after stb.
  - o_grant = 01 one cycle after m0_cyc.
  - s_adr = 0x0010, s_dat_o = 0xA5.
  - m0_ack one cycle wide; m1_ack stays 0.
- Tie after reset: m0_cyc and m1_cyc rise together.
  - m0 granted first; m1 granted 1 dead cycle after m0_cyc drops.
  - next simultaneous tie grants m0 (last-served = m1).
- Lock: m1 owns the bus across 4 reads; m0_cyc asserts mid-cycle.
  - no s_* signal reflects m0 until m1_cyc = 0.
  - m1 read data 0x3C appears only on m1_dat_o.
- Timeout: TIMEOUT = 8; m0 stb held high, no s_ack.
  - m0_err high exactly at cycle 8 of stb, with s_stb = 0 that cycle.
  - o_timeout_cnt = 1.
  - repeating 300 times leaves o_timeout_cnt = 255.
- Boundary: s_ack arrives on the to_hit cycle → m0_ack = 1, m0_err = 0, o_timeout_cnt unchanged.
- RST asserted while OWN1 with stb pending:
  - next cycle o_grant = 0 and all s_*, ack and err outputs are 0.
  - after release, m0 wins a tie.
